// File: rtl/addsub_pkg.sv
// Shared opcode and FSM state encodings for the add/sub accumulator.
package addsub_pkg;

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_ADD  = 2'b01;
  localparam logic [1:0] OP_SUB  = 2'b10;
  localparam logic [1:0] OP_CLR  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_CALC = 2'b01,
    S_RESP = 2'b10
  } state_t;

  function automatic logic is_arith(input logic [1:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/addsub_core.sv
// Combinational WIDTH-bit ripple adder/subtractor: y = a + (b ^ {m}) + m.
// b_x exposes the post-XOR operand so the caller can derive signed overflow.
module addsub_core #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             m,
  output logic [WIDTH-1:0] b_x,
  output logic [WIDTH:0]   y
);

  logic [WIDTH:0] w_c;

  assign w_c[0] = m;
  assign b_x    = b ^ {WIDTH{m}};

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign y[i]     = a[i] ^ b_x[i] ^ w_c[i];
    assign w_c[i+1] = (a[i] & b_x[i]) | (w_c[i] & (a[i] ^ b_x[i]));
  end

  assign y[WIDTH] = w_c[WIDTH];

endmodule

// File: rtl/addsub_accum_seq.sv
// Accumulator front-end: IDLE -> CALC -> RESP command/response sequencer around addsub_core.
// Optional macro ACC_SAT_EN: saturate acc on ADD carry-out / SUB borrow instead of wrapping.
module addsub_accum_seq
  import addsub_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   out_result,
  output logic [WIDTH-1:0] out_acc,
  output logic             out_zero,
  output logic             out_ovf
);

  localparam int MSB = WIDTH - 1;

  state_t             r_state, w_state_nxt;
  logic [1:0]         r_op;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_acc;
  logic [WIDTH:0]     r_result;
  logic               r_valid;
  logic               r_zero;
  logic               r_ovf;

  logic               w_take;
  logic               w_calc;
  logic               w_done;
  logic               w_sub;
  logic [WIDTH-1:0]   w_bx;
  logic [WIDTH:0]     w_sum;
  logic               w_arith_ovf;
  logic [WIDTH-1:0]   w_acc_nxt;
  logic [WIDTH:0]     w_res_nxt;
  logic               w_ovf_nxt;

  assign w_sub = (r_op == OP_SUB);

  addsub_core #(.WIDTH(WIDTH)) u_core (
    .a   (r_acc),
    .b   (r_b),
    .m   (w_sub),
    .b_x (w_bx),
    .y   (w_sum)
  );

  // Two's-complement overflow: operands agree in sign but the sum does not.
  assign w_arith_ovf = (r_acc[MSB] == w_bx[MSB]) && (w_sum[MSB] != r_acc[MSB]);

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    w_take      = 1'b0;
    w_calc      = 1'b0;
    w_done      = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        in_ready = rst_n;
        if (in_valid && rst_n) begin
          w_take      = 1'b1;
          w_state_nxt = S_CALC;
        end
      end
      S_CALC: begin
        w_calc      = 1'b1;
        w_state_nxt = S_RESP;
      end
      S_RESP: begin
        if (r_valid && out_ready) begin
          w_done      = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_acc_nxt = r_acc;
    w_res_nxt = '0;
    w_ovf_nxt = 1'b0;
    unique case (r_op)
      OP_LOAD: begin
        w_acc_nxt = r_b;
        w_res_nxt = {1'b0, r_b};
      end
      OP_ADD: begin
        w_acc_nxt = w_sum[MSB:0];
        w_res_nxt = w_sum;
        w_ovf_nxt = w_arith_ovf;
`ifdef ACC_SAT_EN
        if (w_sum[WIDTH]) begin
          w_acc_nxt = '1;
          w_ovf_nxt = 1'b1;
        end
`endif
      end
      OP_SUB: begin
        w_acc_nxt = w_sum[MSB:0];
        w_res_nxt = w_sum;
        w_ovf_nxt = w_arith_ovf;
`ifdef ACC_SAT_EN
        // Carry-out low on subtract means a borrow (acc < b unsigned).
        if (!w_sum[WIDTH]) begin
          w_acc_nxt = '0;
          w_ovf_nxt = 1'b1;
        end
`endif
      end
      OP_CLR: begin
        w_acc_nxt = '0;
      end
      default: w_acc_nxt = r_acc;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op     <= OP_LOAD;
      r_b      <= '0;
      r_acc    <= '0;
      r_result <= '0;
      r_valid  <= 1'b0;
      r_zero   <= 1'b1;
      r_ovf    <= 1'b0;
    end else begin
      if (w_take) begin
        r_op <= in_op;
        r_b  <= in_b;
      end
      if (w_calc) begin
        r_acc    <= w_acc_nxt;
        r_result <= w_res_nxt;
        r_zero   <= (w_acc_nxt == '0);
        r_ovf    <= w_ovf_nxt;
        r_valid  <= 1'b1;
      end else if (w_done) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign out_valid  = r_valid;
  assign out_result = r_result;
  assign out_acc    = r_acc;
  assign out_zero   = r_zero;
  assign out_ovf    = r_ovf;

endmodule

// File: doc/addsub_accum_seq.md
Name: addsub_accum_seq

Overview:
- Sequential accumulator front-end that owns the A/B/M operand drive of a WIDTH-bit ripple add/subtract datapath and registers the WIDTH+1-bit result.
- Sits directly upstream of the combinational adder-subtractor: the accumulator feeds A, the command operand feeds B, and the opcode selects M.
- Presents a valid/ready command interface to the controller and a valid/ready response interface carrying result and flags.

Parameters:
- WIDTH, 4, operand/accumulator width in bits; result is WIDTH+1.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  command valid
- in_ready  out  1  command accepted when in_valid&&in_ready at clk edge
- in_op  in  2  00 LOAD, 01 ADD, 10 SUB, 11 CLR
- in_b  in  WIDTH  operand B
- out_valid  out  1  response valid
- out_ready  in  1  response consumed when out_valid&&out_ready at clk edge
- out_result  out  WIDTH+1  {carry, sum} of executed op
- out_acc  out  WIDTH  accumulator value after op
- out_zero  out  1  out_acc==0
- out_ovf  out  1  signed overflow (ADD/SUB only)

Behaviour:
- Reset (async, rst_n=0): state=IDLE, acc=0, op/b regs=0, out_valid=0, out_result=0, out_acc=0, out_zero=1, out_ovf=0. in_ready=0 while rst_n=0. Reset mid-operation aborts; pending response is lost.
- FSM states:
  - IDLE: in_ready=1. On handshake, capture in_op and in_b, go to CALC.
  - CALC: in_ready=0. Drive A=acc, B=b_reg, M=(op==SUB). At edge: update acc, register outputs, set out_valid=1, go to RESP.
  - RESP: in_ready=0. Outputs are held stable. On out_valid&&out_ready: out_valid=0, go to IDLE.
- Latency: command accepted at edge N; out_valid=1 after edge N+1. With out_ready held high, out_valid drops at edge N+2 and the next command is accepted at edge N+3 (one command per 3 cycles).
- Arithmetic: all ops are modulo 2^WIDTH on acc.
  - LOAD: acc=b; result={1'b0,b}; ovf=0.
  - ADD: {c,s}=acc+b; acc=s; result={c,s}.
  - SUB: {c,s}=acc+~b+1; acc=s; result={c,s}. c=1 means no borrow (acc>=b unsigned).
  - CLR: acc=0; result=0; ovf=0.
- ovf = (A[msb]==B'[msb]) && (s[msb]!=A[msb]), where B' is the post-XOR operand.
- out_zero reflects the new acc.
- in_valid deasserted in IDLE: no state change. in_op and in_b are ignored outside the handshake.
- out_ready high while out_valid=0 has no effect.

Optional Feature:
- ACC_SAT_EN defined:
  - ADD with carry=1: acc saturates to all-ones.
  - SUB with carry=0 (borrow): acc saturates to 0.
  - out_result still carries the raw {c,s}; out_ovf additionally asserts on a saturation event.
- Not defined: wrap-around only, as described above.

Decomposition:
- Package addsub_pkg: op encoding constants (OP_LOAD=2'b00, OP_ADD=2'b01, OP_SUB=2'b10, OP_CLR=2'b11) and state encoding constants (S_IDLE, S_CALC, S_RESP).
- One sub-module, addsub_core: combinational WIDTH-bit adder/subtractor (inputs a, b, m; output {carry,sum}), XOR-on-B with m as carry-in. The FSM, registers and flag logic stay in the top.

Test Plan:
- Reset then idle: rst_n low mid-CALC -> out_valid=0, out_acc=0, out_zero=1; in_ready=1 in the first IDLE cycle after release.
- LOAD 4'h5 then ADD 4'h3 -> result 5'h08, acc 4'h8, ovf=1 (5+3 signed overflow), zero=0.
- LOAD 4'hF then ADD 4'h1 -> result 5'h10, acc 0, zero=1, ovf=0. With ACC_SAT_EN: acc 4'hF, ovf=1.
- LOAD 4'h3 then SUB 4'h5 -> result 5'h0E (c=0, borrow), acc 4'hE. With ACC_SAT_EN: acc 0, ovf=1.
- Backpressure: out_ready=0 for 5 cycles after out_valid -> outputs stable, in_ready=0; a command presented during the stall is not taken until the cycle after the response handshake.
- Back-to-back stream (LOAD 2, ADD 2, SUB 1, CLR) with out_ready=1 -> one response per 3 cycles, accs 2,4,3,0.
